mc_controller: RTL and testbench

Multicycle control unit for the MIPS datapath built from the team's ALU, register file, flops and muxes. Fetches, decodes and sequences each instruction over several clock cycles with a Moore FSM. Drives every datapath enable and mux select plus the 4-bit ALU control code. Adds a memory wait-state handshake, and optionally adds stall cycles for the ALU's slow divide path.

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_alu_decoder.sv | 30 +++
 rtl/mc_controller.sv | 194 +++++++++++++++++++
 tb/tb_mc_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle MIPS control unit.
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_DIV = 6'b011010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: R-type funct field to 4-bit ALU control code plus validity flag.
`default_nettype none

module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       funct_valid
);

  always_comb begin
    alucontrol  = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_XOR:  alucontrol = ALU_XOR;
      FN_NOR:  alucontrol = ALU_NOR;
      FN_SLT:  alucontrol = ALU_SLT;
      FN_DIV:  alucontrol = ALU_DIV;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the multicycle MIPS datapath with memory wait states.
// Define MC_DIV_STALL_EN to hold RTYPEEX for DIV_CYCLES cycles on div.
`default_nettype none

module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [3:0] rtype_alu;
  logic       funct_valid;
  logic       pcwrite, branch;

  mc_alu_decoder u_alu_decoder (
    .funct       (funct),
    .alucontrol  (rtype_alu),
    .funct_valid (funct_valid)
  );

`ifdef MC_DIV_STALL_EN
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);
  logic [3:0] cnt_q, cnt_d;
`else
  logic unused_div_cycles;
  assign unused_div_cycles = (DIV_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
`ifdef MC_DIV_STALL_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MC_DIV_STALL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef MC_DIV_STALL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid) begin
              state_d = S_RTYPEEX;
`ifdef MC_DIV_STALL_EN
              if (funct == FN_DIV) cnt_d = DIV_LOAD;
`endif
            end else begin
              state_d = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BEQEX;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JEX;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: begin
`ifdef MC_DIV_STALL_EN
        if ((funct == FN_DIV) && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
        else state_d = S_RTYPEWB;
`else
        state_d = S_RTYPEWB;
`endif
      end
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PCSRC_ALU;
    alucontrol = ALU_AND;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMM_SL2;
        alucontrol = ALU_ADD;
        illegal    = !op_supported(op) || ((op == OP_RTYPE) && !funct_valid);
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        alucontrol = rtype_alu;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        branch     = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every side effect immediately, before the state register settles.
    if (reset) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
    pcen = pcwrite | (branch & zero);
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
`default_nettype none

module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MC_DIV_STALL_EN
  localparam int EX_CYCLES = 4;
`else
  localparam int EX_CYCLES = 1;
`endif

  mc_controller #(.DIV_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag);
    chk1({tag, ".mem_req"}, mem_req, 1'b1);
    chk1({tag, ".iord"}, iord, 1'b0);
    chk4({tag, ".alusrcb"}, {2'b00, alusrcb}, 4'b0001);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;
    tick(); tick(); tick();
    chk1("rst.mem_req", mem_req, 1'b0);
    chk1("rst.irwrite", irwrite, 1'b0);
    chk1("rst.pcen", pcen, 1'b0);
    chk1("rst.regwrite", regwrite, 1'b0);
    chk4("rst.alusrcb", {2'b00, alusrcb}, 4'b0001);
    chk4("rst.alucontrol", alucontrol, 4'b0010);

    // lw, zero wait: F, D, MA, MR, WB
    reset = 1'b0; #1;
    chk_fetch("lw.f");
    chk1("lw.f.irwrite", irwrite, 1'b1);
    chk1("lw.f.pcen", pcen, 1'b1);
    tick();
    chk4("lw.d.alusrcb", {2'b00, alusrcb}, 4'b0011);
    chk1("lw.d.illegal", illegal, 1'b0);
    chk1("lw.d.mem_req", mem_req, 1'b0);
    tick();
    chk1("lw.ma.alusrca", alusrca, 1'b1);
    chk4("lw.ma.alusrcb", {2'b00, alusrcb}, 4'b0010);
    tick();
    chk1("lw.mr.mem_req", mem_req, 1'b1);
    chk1("lw.mr.iord", iord, 1'b1);
    chk1("lw.mr.regwrite", regwrite, 1'b0);
    tick();
    chk1("lw.wb.regwrite", regwrite, 1'b1);
    chk1("lw.wb.memtoreg", memtoreg, 1'b1);
    chk1("lw.wb.regdst", regdst, 1'b0);
    tick();
    chk_fetch("lw.end");
    chk1("lw.end.regwrite", regwrite, 1'b0);

    // FETCH wait state
    mem_ready = 1'b0; #1;
    chk1("fw.irwrite", irwrite, 1'b0);
    chk1("fw.pcen", pcen, 1'b0);
    tick();
    chk_fetch("fw.hold");

    // sw with two MEMWR wait cycles
    mem_ready = 1'b1; op = 6'b101011; #1;
    chk1("sw.f.irwrite", irwrite, 1'b1);
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    chk1("sw.w1.memwrite", memwrite, 1'b1);
    chk1("sw.w1.iord", iord, 1'b1);
    tick();
    chk1("sw.w2.memwrite", memwrite, 1'b1);
    tick();
    chk1("sw.w3.memwrite", memwrite, 1'b1);
    mem_ready = 1'b1; #1;
    chk1("sw.w3b.memwrite", memwrite, 1'b1);
    tick();
    chk1("sw.end.memwrite", memwrite, 1'b0);
    chk_fetch("sw.end");

    // beq taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick();
    chk1("beq1.pcen", pcen, 1'b1);
    chk4("beq1.pcsrc", {2'b00, pcsrc}, 4'b0001);
    chk4("beq1.alucontrol", alucontrol, 4'b1010);
    tick();
    chk_fetch("beq1.end");

    // beq not taken
    zero = 1'b0;
    tick(); tick();
    chk1("beq0.pcen", pcen, 1'b0);
    chk4("beq0.pcsrc", {2'b00, pcsrc}, 4'b0001);
    tick();
    chk_fetch("beq0.end");

    // R-type sub
    op = 6'b000000; funct = 6'b100010;
    tick();
    chk1("sub.d.illegal", illegal, 1'b0);
    tick();
    chk4("sub.ex.alucontrol", alucontrol, 4'b1010);
    chk1("sub.ex.alusrca", alusrca, 1'b1);
    chk4("sub.ex.alusrcb", {2'b00, alusrcb}, 4'b0000);
    chk1("sub.ex.regwrite", regwrite, 1'b0);
    tick();
    chk1("sub.wb.regdst", regdst, 1'b1);
    chk1("sub.wb.regwrite", regwrite, 1'b1);
    chk1("sub.wb.memtoreg", memtoreg, 1'b0);
    chk4("sub.wb.alucontrol", alucontrol, 4'b1010);
    tick();
    chk_fetch("sub.end");

    // illegal opcode
    op = 6'b111111;
    tick();
    chk1("ilop.d.illegal", illegal, 1'b1);
    chk1("ilop.d.regwrite", regwrite, 1'b0);
    chk1("ilop.d.memwrite", memwrite, 1'b0);
    tick();
    chk_fetch("ilop.end");
    chk1("ilop.end.illegal", illegal, 1'b0);

    // illegal funct
    op = 6'b000000; funct = 6'b000001;
    tick();
    chk1("ilfn.d.illegal", illegal, 1'b1);
    tick();
    chk_fetch("ilfn.end");
    chk1("ilfn.end.regwrite", regwrite, 1'b0);

    // addi
    op = 6'b001000;
    tick(); tick();
    chk1("addi.ex.alusrca", alusrca, 1'b1);
    chk4("addi.ex.alusrcb", {2'b00, alusrcb}, 4'b0010);
    chk4("addi.ex.alucontrol", alucontrol, 4'b0010);
    tick();
    chk1("addi.wb.regwrite", regwrite, 1'b1);
    chk1("addi.wb.regdst", regdst, 1'b0);
    chk1("addi.wb.memtoreg", memtoreg, 1'b0);
    tick();
    chk_fetch("addi.end");

    // jump
    op = 6'b000010;
    tick(); tick();
    chk1("j.pcen", pcen, 1'b1);
    chk4("j.pcsrc", {2'b00, pcsrc}, 4'b0010);
    tick();
    chk_fetch("j.end");

    // div: EX_CYCLES cycles in RTYPEEX
    op = 6'b000000; funct = 6'b011010;
    tick();
    for (int i = 0; i < EX_CYCLES; i++) begin
      tick();
      chk4("div.ex.alucontrol", alucontrol, 4'b0100);
      chk1("div.ex.regwrite", regwrite, 1'b0);
    end
    tick();
    chk1("div.wb.regwrite", regwrite, 1'b1);
    chk1("div.wb.regdst", regdst, 1'b1);
    tick();
    chk_fetch("div.end");

    // reset asserted in RTYPEEX (mid-stall when enabled) aborts the instruction
    tick(); tick();
    if (EX_CYCLES > 1) tick();
    reset = 1'b1; #1;
    chk1("rmid.mem_req", mem_req, 1'b0);
    chk1("rmid.regwrite", regwrite, 1'b0);
    chk4("rmid.alusrcb", {2'b00, alusrcb}, 4'b0001);
    chk4("rmid.alucontrol", alucontrol, 4'b0010);
    tick();
    chk1("rmid.hold.regwrite", regwrite, 1'b0);
    reset = 1'b0; #1;
    chk_fetch("rmid.fetch");
    chk1("rmid.fetch.irwrite", irwrite, 1'b1);

    // div again after reset: full stall length again
    tick();
    for (int i = 0; i < EX_CYCLES; i++) begin
      tick();
      chk4("div2.ex.alucontrol", alucontrol, 4'b0100);
      chk1("div2.ex.regwrite", regwrite, 1'b0);
    end
    tick();
    chk1("div2.wb.regwrite", regwrite, 1'b1);
    tick();
    chk_fetch("div2.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
